// File: rtl/write_back_unit.sv
// Write-back stage: selects the retiring result, aligns/extends load data,
// drives the registered register-file write triple and stalls on busy loads.
module write_back_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        d_mem_r_in,
  input  logic [1:0]  mux_result,
  input  logic [2:0]  fun_3,
  input  logic [31:0] alu_result,
  input  logic [31:0] imm_in,
  input  logic [31:0] pc_plus_4,
  input  logic [4:0]  write_address_in,
  input  logic        write_reg_en_in,
  input  logic [31:0] d_mem_read_data,
  input  logic        d_mem_busy,
  output logic [31:0] data_out,
  output logic [4:0]  write_address_out,
  output logic        write_reg_enable_out,
  output logic        stall_out,
  output logic [31:0] retired_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned F3_W  = 3;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t state, next_state;

  logic [SEL_W-1:0] lat_mux;
  logic [F3_W-1:0]  lat_fun3;
  logic [1:0]       lat_off;
  logic [AW-1:0]    lat_rd;
  logic             lat_we;

  logic [SEL_W-1:0] sel_mux;
  logic [F3_W-1:0]  sel_fun3;
  logic [1:0]       sel_off;
  logic [AW-1:0]    sel_rd;
  logic             sel_we;
  logic             commit_c;
  logic             issue_wait_c;
  logic [XLEN-1:0]  load_c;
  logic [XLEN-1:0]  result_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state, commit strobe and stall
  always_comb begin
    next_state   = state;
    commit_c     = 1'b0;
    issue_wait_c = 1'b0;
    stall_out    = 1'b0;
    case (state)
      IDLE: begin
        stall_out = mem_valid & d_mem_r_in & d_mem_busy;
        if (mem_valid) begin
          if (d_mem_r_in && d_mem_busy) begin
            issue_wait_c = 1'b1;
            next_state   = WAIT_MEM;
          end else begin
            commit_c = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        stall_out = d_mem_busy;
        if (!d_mem_busy) begin
          commit_c   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Fields of a load parked while memory is busy
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_mux  <= '0;
      lat_fun3 <= '0;
      lat_off  <= '0;
      lat_rd   <= '0;
      lat_we   <= 1'b0;
    end else if (issue_wait_c) begin
      lat_mux  <= mux_result;
      lat_fun3 <= fun_3;
      lat_off  <= alu_result[1:0];
      lat_rd   <= write_address_in;
      lat_we   <= write_reg_en_in;
    end
  end

  always_comb begin
    sel_mux  = mux_result;
    sel_fun3 = fun_3;
    sel_off  = alu_result[1:0];
    sel_rd   = write_address_in;
    sel_we   = write_reg_en_in;
    if (state == WAIT_MEM) begin
      sel_mux  = lat_mux;
      sel_fun3 = lat_fun3;
      sel_off  = lat_off;
      sel_rd   = lat_rd;
      sel_we   = lat_we;
    end
  end

  // Lane select and sign/zero extension of load data
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = d_mem_read_data[8*sel_off +: 8];
    lane_h = sel_off[1] ? d_mem_read_data[31:16] : d_mem_read_data[15:0];
    case (sel_fun3)
      3'b000:  load_c = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_c = {24'h0, lane_b};
      3'b001:  load_c = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_c = {16'h0, lane_h};
      default: load_c = d_mem_read_data;
    endcase
  end

  always_comb begin
    case (sel_mux)
      2'b00:   result_c = alu_result;
      2'b01:   result_c = load_c;
      2'b10:   result_c = imm_in;
      default: result_c = pc_plus_4;
    endcase
  end

  // Registered write triple and retirement counter
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out             <= '0;
      write_address_out    <= '0;
      write_reg_enable_out <= 1'b0;
      retired_count        <= '0;
    end else begin
      write_reg_enable_out <= 1'b0;
      if (commit_c) begin
        data_out             <= result_c;
        write_address_out    <= sel_rd;
        write_reg_enable_out <= sel_we & (sel_rd != AW'(0));
        retired_count        <= retired_count + XLEN'(1);
      end
    end
  end

endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit: ALU/load/imm/link selects, busy-load
// stall, reset during a pending load and counter wrap.
module tb_write_back_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        d_mem_r_in;
  logic [1:0]  mux_result;
  logic [2:0]  fun_3;
  logic [31:0] alu_result;
  logic [31:0] imm_in;
  logic [31:0] pc_plus_4;
  logic [4:0]  write_address_in;
  logic        write_reg_en_in;
  logic [31:0] d_mem_read_data;
  logic        d_mem_busy;
  logic [31:0] data_out;
  logic [4:0]  write_address_out;
  logic        write_reg_enable_out;
  logic        stall_out;
  logic [31:0] retired_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  write_back_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .mem_valid            (mem_valid),
    .d_mem_r_in           (d_mem_r_in),
    .mux_result           (mux_result),
    .fun_3                (fun_3),
    .alu_result           (alu_result),
    .imm_in               (imm_in),
    .pc_plus_4            (pc_plus_4),
    .write_address_in     (write_address_in),
    .write_reg_en_in      (write_reg_en_in),
    .d_mem_read_data      (d_mem_read_data),
    .d_mem_busy           (d_mem_busy),
    .data_out             (data_out),
    .write_address_out    (write_address_out),
    .write_reg_enable_out (write_reg_enable_out),
    .stall_out            (stall_out),
    .retired_count        (retired_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic [1:0] mux, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [4:0] rd, input logic we);
    mem_valid        = v;
    d_mem_r_in       = ld;
    mux_result       = mux;
    fun_3            = f3;
    alu_result       = alu;
    write_address_in = rd;
    write_reg_en_in  = we;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 5'd0, 1'b0);
    imm_in = 32'h0; pc_plus_4 = 32'h0; d_mem_read_data = 32'h0; d_mem_busy = 1'b0;
    tick(); tick();
    chk("rst_data", data_out, 32'h0);
    chk("rst_addr", 32'(write_address_out), 32'h0);
    chk("rst_en", 32'(write_reg_enable_out), 32'h0);
    chk("rst_count", retired_count, 32'h0);
    chk("rst_stall", 32'(stall_out), 32'h0);

    // ALU op, then a bubble
    reset = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_1234, 5'd5, 1'b1);
    tick();
    chk("alu_data", data_out, 32'h0000_1234);
    chk("alu_addr", 32'(write_address_out), 32'd5);
    chk("alu_en", 32'(write_reg_enable_out), 32'd1);
    chk("alu_count", retired_count, 32'd1);
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 5'd5, 1'b1);
    tick();
    chk("bubble_en", 32'(write_reg_enable_out), 32'd0);
    chk("bubble_count", retired_count, 32'd1);

    // Loads that do not stall
    d_mem_read_data = 32'h80FF_7F01;
    drive(1'b1, 1'b1, 2'b01, 3'b000, 32'h0000_0003, 5'd6, 1'b1);
    #1 chk("lb_stall", 32'(stall_out), 32'd0);
    tick();
    chk("lb_off3", data_out, 32'hFFFF_FF80);
    drive(1'b1, 1'b1, 2'b01, 3'b101, 32'h0000_0002, 5'd6, 1'b1);
    tick();
    chk("lhu_off2", data_out, 32'h0000_80FF);
    drive(1'b1, 1'b1, 2'b01, 3'b001, 32'h0000_0003, 5'd6, 1'b1);
    tick();
    chk("lh_off3", data_out, 32'hFFFF_80FF);
    drive(1'b1, 1'b1, 2'b01, 3'b100, 32'h0000_0001, 5'd6, 1'b1);
    tick();
    chk("lbu_off1", data_out, 32'h0000_007F);
    chk("load_count", retired_count, 32'd5);

    // Busy load, stall for issue cycle plus two wait cycles
    d_mem_busy = 1'b1;
    d_mem_read_data = 32'h1111_1111;
    drive(1'b1, 1'b1, 2'b01, 3'b010, 32'h0000_0000, 5'd7, 1'b1);
    #1 chk("busy_stall0", 32'(stall_out), 32'd1);
    tick();
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0000_0013, 5'd9, 1'b0);
    #1 chk("busy_stall1", 32'(stall_out), 32'd1);
    chk("busy_en1", 32'(write_reg_enable_out), 32'd0);
    tick();
    chk("busy_stall2", 32'(stall_out), 32'd1);
    chk("busy_count", retired_count, 32'd5);
    tick();
    d_mem_busy = 1'b0;
    d_mem_read_data = 32'hDEAD_BEEF;
    #1 chk("busy_drop_stall", 32'(stall_out), 32'd0);
    tick();
    chk("busy_data", data_out, 32'hDEAD_BEEF);
    chk("busy_addr", 32'(write_address_out), 32'd7);
    chk("busy_en", 32'(write_reg_enable_out), 32'd1);
    chk("busy_commit_count", retired_count, 32'd6);
    tick();
    chk("post_busy_en", 32'(write_reg_enable_out), 32'd0);
    chk("post_busy_count", retired_count, 32'd6);

    // Back-to-back: JAL, LUI, ALU rd=0, ALU rd=3
    pc_plus_4 = 32'h0000_0104;
    drive(1'b1, 1'b0, 2'b11, 3'b000, 32'h0000_0055, 5'd1, 1'b1);
    tick();
    chk("jal_data", data_out, 32'h0000_0104);
    chk("jal_en", 32'(write_reg_enable_out), 32'd1);
    imm_in = 32'hABCD_E000;
    drive(1'b1, 1'b0, 2'b10, 3'b000, 32'h0000_0055, 5'd2, 1'b1);
    tick();
    chk("lui_data", data_out, 32'hABCD_E000);
    chk("lui_addr", 32'(write_address_out), 32'd2);
    drive(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_0055, 5'd0, 1'b1);
    tick();
    chk("rd0_en", 32'(write_reg_enable_out), 32'd0);
    drive(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_0077, 5'd3, 1'b1);
    tick();
    chk("alu3_en", 32'(write_reg_enable_out), 32'd1);
    chk("alu3_data", data_out, 32'h0000_0077);
    chk("b2b_count", retired_count, 32'd10);

    // Reset while a load waits on memory
    d_mem_busy = 1'b1;
    drive(1'b1, 1'b1, 2'b01, 3'b010, 32'h0, 5'd8, 1'b1);
    tick();
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 5'd0, 1'b0);
    reset = 1'b1;
    tick();
    chk("rstw_stall", 32'(stall_out), 32'd0);
    chk("rstw_en", 32'(write_reg_enable_out), 32'd0);
    chk("rstw_count", retired_count, 32'd0);
    reset = 1'b0;
    d_mem_busy = 1'b0;
    tick();
    chk("rstw_nocommit_en", 32'(write_reg_enable_out), 32'd0);
    chk("rstw_nocommit_count", retired_count, 32'd0);

    // Counter wrap
    force dut.retired_count = 32'hFFFF_FFFF;
    #1 release dut.retired_count;
    #1 chk("wrap_pre", retired_count, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 5'd4, 1'b1);
    tick();
    chk("wrap", retired_count, 32'h0);
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 5'd0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
